seg_display_arbiter: RTL and testbench

Shares the single 4-digit seven-segment display between NUM_REQ requesters, such as a switch-value viewer, a counter and an error-code source. The block grants one requester at a time using a round-robin order, latches that requester's 16-bit value, and holds it on the display for a minimum dwell time. Its N output drives the 16-bit hex input of the existing multiplexed seven-segment driver.

---
 rtl/seg_disp_pkg.sv | 8 +
 rtl/seg_display_arbiter_rr_pick.sv | 22 ++
 rtl/seg_display_arbiter.sv | 84 ++++++++
 tb/tb_seg_display_arbiter.sv | 146 ++++++++++++++
 4 files changed

// File: rtl/seg_disp_pkg.sv
// seg_disp_pkg: shared types and constants for the seven-segment display arbiter.
package seg_disp_pkg;
  localparam int DIGIT_W = 16;
  localparam int MAX_REQ = 4;
  localparam int SRC_W = 2;
  typedef logic [SRC_W-1:0] src_t;
  typedef enum logic {IDLE, SHOW} state_t;
endpackage

// File: rtl/seg_display_arbiter_rr_pick.sv
// rr_pick: round-robin winner search starting just above the last winner.
module rr_pick import seg_disp_pkg::*; #(
  parameter int NUM_REQ = 3
) (
  input  logic [NUM_REQ-1:0] req,
  input  src_t               last,
  output src_t               winner,
  output logic               valid
);
  always_comb begin
    winner = '0;
    valid = 1'b0;
    for (int j = NUM_REQ - 1; j >= 0; j--)
      if (req[j]) begin
        winner = src_t'(j);
        valid = 1'b1;
      end
    // lowest requester above last overrides the wrapped-around choice
    for (int j = NUM_REQ - 1; j >= 0; j--)
      if (req[j] && src_t'(j) > last) winner = src_t'(j);
  end
endmodule

// File: rtl/seg_display_arbiter.sv
// seg_display_arbiter: round-robin sharing of one 16-bit display value with a minimum dwell.
module seg_display_arbiter import seg_disp_pkg::*; #(
  parameter int NUM_REQ = 3,
  parameter int HOLD_CYCLES = 50000000,
  parameter int CNT_W = 26
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic [NUM_REQ-1:0]         req,
  input  logic [DIGIT_W*NUM_REQ-1:0] data,
  output logic [NUM_REQ-1:0]         grant,
  output logic [DIGIT_W-1:0]         N,
  output logic [SRC_W-1:0]           active_src,
  output logic                       busy
);
  state_t state, state_nxt;
  logic [CNT_W-1:0] cnt, cnt_nxt;
  src_t last, last_nxt, winner, src_nxt;
  logic valid, busy_nxt;
  logic [DIGIT_W-1:0] n_nxt;
  logic [NUM_REQ-1:0] grant_nxt;
  logic [MAX_REQ-1:0] req_x;
  logic [DIGIT_W-1:0] words [MAX_REQ];
  assign req_x = MAX_REQ'(req);
  for (genvar g = 0; g < MAX_REQ; g++) begin : g_words
    if (g < NUM_REQ) begin : g_used
      assign words[g] = data[DIGIT_W*g +: DIGIT_W];
    end else begin : g_absent
      assign words[g] = '0;
    end
  end
  rr_pick #(.NUM_REQ(NUM_REQ)) u_pick (
    .req(req),
    .last(last),
    .winner(winner),
    .valid(valid)
  );
  always_comb begin
    state_nxt = state;
    cnt_nxt = cnt;
    last_nxt = last;
    src_nxt = active_src;
    n_nxt = N;
    grant_nxt = '0;
    busy_nxt = busy;
    if (state == SHOW && cnt != '0) begin
      cnt_nxt = cnt - 1'b1;
      // a live source may refresh its value without restarting the dwell
      if (req_x[active_src]) begin
        n_nxt = words[active_src];
        grant_nxt = NUM_REQ'(1) << active_src;
      end
    end else if (valid) begin
      state_nxt = SHOW;
      cnt_nxt = CNT_W'(HOLD_CYCLES - 1);
      last_nxt = winner;
      src_nxt = winner;
      n_nxt = words[winner];
      grant_nxt = NUM_REQ'(1) << winner;
      busy_nxt = 1'b1;
    end else begin
      state_nxt = IDLE;
      busy_nxt = 1'b0;
    end
  end
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      state <= IDLE;
      cnt <= '0;
      last <= src_t'(NUM_REQ - 1);
      active_src <= '0;
      N <= '0;
      grant <= '0;
      busy <= 1'b0;
    end else begin
      state <= state_nxt;
      cnt <= cnt_nxt;
      last <= last_nxt;
      active_src <= src_nxt;
      N <= n_nxt;
      grant <= grant_nxt;
      busy <= busy_nxt;
    end
endmodule

// File: tb/tb_seg_display_arbiter.sv
// tb_seg_display_arbiter: directed checks of arbitration, dwell, refresh and reset.
module tb_seg_display_arbiter;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic [2:0] req = '0;
  logic [47:0] data = '0;
  logic [2:0] grant;
  logic [15:0] N;
  logic [1:0] active_src;
  logic busy;
  int checks = 0;
  int passed = 0;
  seg_display_arbiter #(.NUM_REQ(3), .HOLD_CYCLES(4), .CNT_W(3)) dut (
    .clk(clk),
    .rst_n(rst_n),
    .req(req),
    .data(data),
    .grant(grant),
    .N(N),
    .active_src(active_src),
    .busy(busy)
  );
  always #5 clk = ~clk;
  // outputs packed as {grant, N, active_src, busy}
  task automatic cmp(input string name, input logic [21:0] exp);
    checks++;
    if ({grant, N, active_src, busy} !== exp)
      $display("FAIL %s: got grant=%b N=%h src=%0d busy=%b, want grant=%b N=%h src=%0d busy=%b",
               name, grant, N, active_src, busy, exp[21:19], exp[18:3], exp[2:1], exp[0]);
    else passed++;
  endtask
  task automatic do_reset();
    req = '0;
    rst_n = 1'b0;
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
  endtask
  task automatic test_reset();
    do_reset();
    cmp("reset_values", {3'b000, 16'h0000, 2'd0, 1'b0});
  endtask
  task automatic test_single();
    do_reset();
    data = {16'h0000, 16'h0000, 16'h1234};
    req = 3'b001;
    @(negedge clk);
    cmp("single_grant", {3'b001, 16'h1234, 2'd0, 1'b1});
    req = '0;
    for (int i = 1; i <= 3; i++) begin
      @(negedge clk);
      cmp($sformatf("single_dwell%0d", i), {3'b000, 16'h1234, 2'd0, 1'b1});
    end
    @(negedge clk);
    cmp("single_busy_fall", {3'b000, 16'h1234, 2'd0, 1'b0});
  endtask
  task automatic test_round_robin();
    logic [2:0] oh;
    logic [1:0] src;
    logic [15:0] val;
    do_reset();
    data = {16'h0C00, 16'h00B0, 16'h000A};
    req = 3'b111;
    oh = 3'b001;
    src = 2'd0;
    val = 16'h000A;
    for (int k = 0; k <= 12; k++) begin
      @(negedge clk);
      if (k % 4 == 0) begin
        src = 2'((k / 4) % 3);
        oh = 3'b001 << src;
        val = (src == 2'd0) ? 16'h000A : (src == 2'd1) ? 16'h00B0 : 16'h0C00;
      end
      // between expiries the held request of the shown source refreshes it
      cmp($sformatf("rr_cycle%0d", k), {oh, val, src, 1'b1});
    end
    req = '0;
  endtask
  task automatic test_same_source();
    do_reset();
    data = {16'h3333, 16'h2222, 16'h1111};
    req = 3'b001;
    @(negedge clk);
    cmp("same_first_grant", {3'b001, 16'h1111, 2'd0, 1'b1});
    req = '0;
    @(negedge clk);
    cmp("same_quiet", {3'b000, 16'h1111, 2'd0, 1'b1});
    req = 3'b001;
    data[15:0] = 16'h5555;
    @(negedge clk);
    cmp("same_refresh", {3'b001, 16'h5555, 2'd0, 1'b1});
    req = 3'b010;
    @(negedge clk);
    cmp("same_wait", {3'b000, 16'h5555, 2'd0, 1'b1});
    @(negedge clk);
    cmp("same_expiry_grant", {3'b010, 16'h2222, 2'd1, 1'b1});
    req = '0;
  endtask
  task automatic test_withdrawn();
    do_reset();
    data = {16'h3333, 16'h2222, 16'h0F0F};
    req = 3'b001;
    @(negedge clk);
    cmp("wd_grant", {3'b001, 16'h0F0F, 2'd0, 1'b1});
    req = '0;
    @(negedge clk);
    req = 3'b010;
    @(negedge clk);
    cmp("wd_pulse", {3'b000, 16'h0F0F, 2'd0, 1'b1});
    req = '0;
    @(negedge clk);
    cmp("wd_last_dwell", {3'b000, 16'h0F0F, 2'd0, 1'b1});
    @(negedge clk);
    cmp("wd_idle", {3'b000, 16'h0F0F, 2'd0, 1'b0});
    @(negedge clk);
    cmp("wd_not_remembered", {3'b000, 16'h0F0F, 2'd0, 1'b0});
  endtask
  task automatic test_async_reset();
    do_reset();
    data = {16'h3333, 16'h2222, 16'hBEEF};
    req = 3'b001;
    @(negedge clk);
    cmp("ar_grant", {3'b001, 16'hBEEF, 2'd0, 1'b1});
    req = '0;
    @(negedge clk);
    @(negedge clk);
    #2 rst_n = 1'b0;
    #1 cmp("ar_async_clear", {3'b000, 16'h0000, 2'd0, 1'b0});
    @(negedge clk);
    rst_n = 1'b1;
    req = 3'b110;
    @(negedge clk);
    cmp("ar_after_release", {3'b010, 16'h2222, 2'd1, 1'b1});
    req = '0;
  endtask
  initial begin
    test_reset();
    test_single();
    test_round_robin();
    test_same_source();
    test_withdrawn();
    test_async_reset();
    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end
endmodule
